pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives PC and pipeline-register write enables and flushes from three sources: load-use hazards (ID vs EX), EX-stage redirects (taken branch or jump, target computed from the B/J immediate), and data-memory wait handshakes.
- Holds the pipeline in a boot bubble after reset and halts permanently on memory timeout or a misaligned redirect.
- Exports saturating stall and flush counters for performance visibility.

---
 rtl/core_pkg.sv | 46 ++++
 rtl/sat_counter.sv | 18 +
 rtl/pipe_hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types for the pipeline hazard controller: sequencer states and the
// per-stage enable/flush bundle.
package core_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_we;
    logic pc_sel_redirect;
    logic if_id_we;
    logic id_ex_we;
    logic ex_mem_we;
    logic if_id_flush;
    logic id_ex_flush;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_RESET = '{pc_we: 1'b0, pc_sel_redirect: 1'b0,
                                         if_id_we: 1'b0, id_ex_we: 1'b0, ex_mem_we: 1'b0,
                                         if_id_flush: 1'b1, id_ex_flush: 1'b1};
  localparam stage_ctrl_t CTRL_FREEZE = '{pc_we: 1'b0, pc_sel_redirect: 1'b0,
                                          if_id_we: 1'b0, id_ex_we: 1'b0, ex_mem_we: 1'b0,
                                          if_id_flush: 1'b0, id_ex_flush: 1'b0};
  localparam stage_ctrl_t CTRL_REDIRECT = '{pc_we: 1'b1, pc_sel_redirect: 1'b1,
                                            if_id_we: 1'b1, id_ex_we: 1'b1, ex_mem_we: 1'b1,
                                            if_id_flush: 1'b1, id_ex_flush: 1'b1};
  // ID instruction stays put while a bubble enters EX behind the load
  localparam stage_ctrl_t CTRL_BUBBLE = '{pc_we: 1'b0, pc_sel_redirect: 1'b0,
                                          if_id_we: 1'b0, id_ex_we: 1'b1, ex_mem_we: 1'b1,
                                          if_id_flush: 1'b0, id_ex_flush: 1'b1};
  localparam stage_ctrl_t CTRL_NORMAL = '{pc_we: 1'b1, pc_sel_redirect: 1'b0,
                                          if_id_we: 1'b1, id_ex_we: 1'b1, ex_mem_we: 1'b1,
                                          if_id_flush: 1'b0, id_ex_flush: 1'b0};

  function automatic logic src_hits(input logic [4:0] rs, input logic uses,
                                    input logic [4:0] rd);
    return uses && (rs == rd);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: boot bubble, load-use
// bubbles, EX redirects, data-memory waits and fatal-error halt.
module pipe_hazard_ctrl
  import core_pkg::*;
#(
  parameter int BOOT_CYCLES = 4,
  parameter int TIMEOUT     = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_target,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             pc_sel_redirect,
  output logic [31:0]      redirect_pc,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic             err_timeout,
  output logic             err_misalign,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);
  localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

  state_t      state, state_n;
  logic [3:0]  boot_cnt, boot_cnt_n;
  logic [7:0]  wait_cnt, wait_cnt_n;
  logic [8:0]  wait_inc;
  logic        err_timeout_n, err_misalign_n;
  logic        freeze, redir, lu, misalign;
  logic        stall_inc, flush_inc;
  stage_ctrl_t ctrl;

  assign freeze   = dmem_req && !dmem_ready;
  assign redir    = ex_valid && ex_redirect;
  assign misalign = (ex_target[1:0] != 2'b00);
  assign lu       = ex_valid && ex_is_load && (ex_rd != REG_ZERO) && id_valid &&
                    (src_hits(id_rs1, id_uses_rs1, ex_rd) ||
                     src_hits(id_rs2, id_uses_rs2, ex_rd));
  assign wait_inc = {1'b0, wait_cnt} + 9'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= BOOT;
      boot_cnt     <= '0;
      wait_cnt     <= '0;
      err_timeout  <= 1'b0;
      err_misalign <= 1'b0;
    end else begin
      state        <= state_n;
      boot_cnt     <= boot_cnt_n;
      wait_cnt     <= wait_cnt_n;
      err_timeout  <= err_timeout_n;
      err_misalign <= err_misalign_n;
    end
  end

  // Memory freeze outranks everything so a pending redirect or load-use is
  // replayed on the release cycle with the EX instruction still in place.
  always_comb begin
    state_n        = state;
    boot_cnt_n     = boot_cnt;
    wait_cnt_n     = wait_cnt;
    err_timeout_n  = err_timeout;
    err_misalign_n = err_misalign;
    ctrl           = CTRL_RESET;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;

    case (state)
      BOOT: begin
        boot_cnt_n = boot_cnt + 4'd1;
        if (boot_cnt == BOOT_LAST) begin
          state_n    = RUN;
          boot_cnt_n = '0;
        end
      end

      RUN, MEM_WAIT: begin
        if (freeze) begin
          ctrl = CTRL_FREEZE;
          if (state == RUN) begin
            state_n    = MEM_WAIT;
            wait_cnt_n = 8'd1;
          end else begin
            wait_cnt_n = wait_inc[7:0];
            if (wait_inc == TIMEOUT_W) begin
              state_n       = HALT;
              err_timeout_n = 1'b1;
            end
          end
        end else begin
          state_n    = RUN;
          wait_cnt_n = '0;
          if (redir && misalign) begin
            ctrl           = CTRL_FREEZE;
            state_n        = HALT;
            err_misalign_n = 1'b1;
          end else if (redir) begin
            ctrl      = CTRL_REDIRECT;
            flush_inc = 1'b1;
          end else if (lu) begin
            ctrl = CTRL_BUBBLE;
          end else begin
            ctrl = CTRL_NORMAL;
          end
        end
        stall_inc = !ctrl.pc_we;
      end

      HALT: begin
        ctrl = CTRL_FREEZE;
      end
    endcase
  end

  assign pc_we           = ctrl.pc_we;
  assign pc_sel_redirect = ctrl.pc_sel_redirect;
  assign if_id_we        = ctrl.if_id_we;
  assign id_ex_we        = ctrl.id_ex_we;
  assign ex_mem_we       = ctrl.ex_mem_we;
  assign if_id_flush     = ctrl.if_id_flush;
  assign id_ex_flush     = ctrl.id_ex_flush;
  assign redirect_pc     = ex_target;
  assign halted          = (state == HALT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, hand-written
// multi-cycle sequences and random stimulus against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int BOOT_CYCLES = 4;
  localparam int TIMEOUT     = 64;
  localparam int CNT_W       = 6;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  // {pc_we, pc_sel_redirect, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush}
  localparam logic [6:0] C_BOOT  = 7'b0000011;
  localparam logic [6:0] C_NORM  = 7'b1011100;
  localparam logic [6:0] C_LU    = 7'b0001101;
  localparam logic [6:0] C_REDIR = 7'b1111111;
  localparam logic [6:0] C_FRZ   = 7'b0000000;
  localparam logic [6:0] C_HALT  = 7'b0000000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             id_valid, id_uses_rs1, id_uses_rs2;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             ex_valid, ex_is_load, ex_redirect;
  logic [31:0]      ex_target;
  logic             dmem_req, dmem_ready;
  logic             pc_we, pc_sel_redirect, if_id_we, id_ex_we, ex_mem_we;
  logic             if_id_flush, id_ex_flush, halted, err_timeout, err_misalign;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic [6:0]       dut_ctrl;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .BOOT_CYCLES(BOOT_CYCLES), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_redirect(ex_redirect), .ex_target(ex_target),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_we(pc_we), .pc_sel_redirect(pc_sel_redirect), .redirect_pc(redirect_pc),
    .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .halted(halted), .err_timeout(err_timeout), .err_misalign(err_misalign),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  assign dut_ctrl = {pc_we, pc_sel_redirect, if_id_we, id_ex_we, ex_mem_we,
                     if_id_flush, id_ex_flush};

  typedef struct {
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic        ex_valid;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic        dmem_req;
    logic        dmem_ready;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [6:0] ctrl;
    int         stall;
    int         flush;
  } vec_t;

  int    n_vec = 0;
  int    n_err = 0;
  stim_t cur;
  stim_t idle_s;
  vec_t  tbl[17];

  // Behavioural model: age since reset, consecutive frozen cycles, sticky halt.
  int m_age, m_frozen, m_stall, m_flush;
  bit m_halt, m_errt, m_errm;

  function automatic stim_t mk(input bit idv, input logic [4:0] rs1, input logic [4:0] rs2,
                               input bit u1, input bit u2, input bit exv, input bit ld,
                               input logic [4:0] rd, input bit rdr, input logic [31:0] tgt,
                               input bit req, input bit rdy);
    stim_t s;
    s.id_valid = idv;   s.id_rs1 = rs1;     s.id_rs2 = rs2;
    s.id_uses_rs1 = u1; s.id_uses_rs2 = u2;
    s.ex_valid = exv;   s.ex_is_load = ld;  s.ex_rd = rd;
    s.ex_redirect = rdr; s.ex_target = tgt;
    s.dmem_req = req;   s.dmem_ready = rdy;
    return s;
  endfunction

  function automatic logic [6:0] modelCtrl(input stim_t s);
    bit frz, rdr, hz;
    frz = s.dmem_req && !s.dmem_ready;
    rdr = s.ex_valid && s.ex_redirect;
    hz  = s.ex_valid && s.ex_is_load && (s.ex_rd != 5'd0) && s.id_valid &&
          ((s.id_uses_rs1 && s.id_rs1 == s.ex_rd) || (s.id_uses_rs2 && s.id_rs2 == s.ex_rd));
    if (m_age < BOOT_CYCLES) return C_BOOT;
    if (m_halt)              return C_HALT;
    if (frz)                 return C_FRZ;
    if (rdr)                 return (s.ex_target[1:0] != 2'b00) ? C_FRZ : C_REDIR;
    if (hz)                  return C_LU;
    return C_NORM;
  endfunction

  task automatic modelReset();
    m_age = 0; m_frozen = 0; m_stall = 0; m_flush = 0;
    m_halt = 0; m_errt = 0; m_errm = 0;
  endtask

  task automatic modelStep(input stim_t s);
    logic [6:0] c;
    bit frz, rdr;
    c   = modelCtrl(s);
    frz = s.dmem_req && !s.dmem_ready;
    rdr = s.ex_valid && s.ex_redirect;
    if (m_age < BOOT_CYCLES) begin
      m_age++;
    end else if (!m_halt) begin
      if (!c[6]) m_stall = (m_stall >= CNT_MAX) ? CNT_MAX : m_stall + 1;
      if (frz) begin
        m_frozen++;
        if (m_frozen == TIMEOUT) begin m_halt = 1; m_errt = 1; end
      end else begin
        m_frozen = 0;
        if (rdr && s.ex_target[1:0] != 2'b00) begin
          m_halt = 1; m_errm = 1;
        end else if (rdr) begin
          m_flush = (m_flush >= CNT_MAX) ? CNT_MAX : m_flush + 1;
        end
      end
    end
  endtask

  always @(posedge clk) if (!rst) modelStep(cur);

  task automatic applyStimulus(input stim_t s);
    id_valid = s.id_valid;       id_rs1 = s.id_rs1;   id_rs2 = s.id_rs2;
    id_uses_rs1 = s.id_uses_rs1; id_uses_rs2 = s.id_uses_rs2;
    ex_valid = s.ex_valid;       ex_is_load = s.ex_is_load; ex_rd = s.ex_rd;
    ex_redirect = s.ex_redirect; ex_target = s.ex_target;
    dmem_req = s.dmem_req;       dmem_ready = s.dmem_ready;
    cur = s;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic [6:0] ectrl, input bit ehalt,
                             input int estall, input int eflush, input bit eto, input bit emis);
    chk({name, ".ctrl"},     32'(dut_ctrl),     32'(ectrl));
    chk({name, ".rpc"},      redirect_pc,       cur.ex_target);
    chk({name, ".halted"},   32'(halted),       32'(ehalt));
    chk({name, ".stall"},    32'(stall_cycles), estall);
    chk({name, ".flush"},    32'(flush_count),  eflush);
    chk({name, ".err_to"},   32'(err_timeout),  32'(eto));
    chk({name, ".err_mis"},  32'(err_misalign), 32'(emis));
  endtask

  // Leaves the caller one negedge before the first RUN cycle.
  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    modelReset();
    applyStimulus(idle_s);
    @(negedge clk);
    rst = 1'b0;
    repeat (BOOT_CYCLES - 1) @(negedge clk);
  endtask

  task automatic addVec(input int i, input stim_t s, input logic [6:0] c,
                        input int st, input int fl);
    tbl[i].s = s; tbl[i].ctrl = c; tbl[i].stall = st; tbl[i].flush = fl;
  endtask

  initial begin
    stim_t s_frz, s_rs;
    idle_s = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    s_frz  = mk(1, 9, 0, 1, 0, 1, 1, 9, 0, 32'h0, 1, 0);

    addVec(0,  idle_s,                                          C_NORM,  0, 0);
    addVec(1,  mk(1, 0, 5, 0, 1, 1, 1, 5, 0, 32'h0,   0, 0),    C_LU,    0, 0);
    addVec(2,  idle_s,                                          C_NORM,  1, 0);
    addVec(3,  mk(1, 0, 0, 1, 1, 1, 1, 0, 0, 32'h0,   0, 0),    C_NORM,  1, 0);
    addVec(4,  mk(0, 7, 0, 1, 0, 1, 1, 7, 0, 32'h0,   0, 0),    C_NORM,  1, 0);
    addVec(5,  mk(1, 7, 3, 0, 1, 1, 1, 7, 0, 32'h0,   0, 0),    C_NORM,  1, 0);
    addVec(6,  mk(1, 0, 5, 0, 1, 1, 1, 5, 1, 32'h100, 0, 0),    C_REDIR, 1, 0);
    addVec(7,  idle_s,                                          C_NORM,  1, 1);
    addVec(8,  mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200, 0, 0),    C_NORM,  1, 1);
    addVec(9,  mk(1, 9, 0, 1, 0, 1, 1, 9, 0, 32'h0,   0, 0),    C_LU,    1, 1);
    addVec(10, s_frz,                                           C_FRZ,   2, 1);
    addVec(11, mk(1, 9, 0, 1, 0, 1, 1, 9, 0, 32'h0,   1, 1),    C_LU,    3, 1);
    addVec(12, mk(1, 9, 0, 1, 0, 1, 0, 9, 0, 32'h0,   0, 0),    C_NORM,  4, 1);
    addVec(13, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   0, 1),    C_NORM,  4, 1);
    addVec(14, mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h300, 1, 0),    C_FRZ,   4, 1);
    addVec(15, mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h300, 1, 1),    C_REDIR, 5, 1);
    addVec(16, idle_s,                                          C_NORM,  5, 2);

    // Reset values, then exactly BOOT_CYCLES cycles of boot bubble
    modelReset();
    applyStimulus(idle_s);
    repeat (3) @(negedge clk);
    #1 checkOutput("reset", C_BOOT, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < BOOT_CYCLES; i++) begin
      if (i > 0) @(negedge clk);
      #1 chk($sformatf("boot%0d.ctrl", i), 32'(dut_ctrl), 32'(C_BOOT));
    end
    @(negedge clk);
    #1 checkOutput("boot_exit", C_NORM, 0, 0, 0, 0, 0);

    doReset();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      applyStimulus(tbl[i].s);
      #1 checkOutput($sformatf("vec%0d", i), tbl[i].ctrl, 0, tbl[i].stall, tbl[i].flush, 0, 0);
    end

    // Three wait cycles then release
    doReset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      applyStimulus(s_frz);
      #1 checkOutput($sformatf("wait3_%0d", i), C_FRZ, 0, i, 0, 0, 0);
    end
    @(negedge clk);
    applyStimulus(idle_s);
    #1 checkOutput("wait3_release", C_NORM, 0, 3, 0, 0, 0);
    @(negedge clk);
    #1 checkOutput("wait3_after", C_NORM, 0, 3, 0, 0, 0);

    // Timeout: TIMEOUT frozen cycles halt the pipe; stall counter saturates
    doReset();
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      applyStimulus(s_frz);
      #1 checkOutput($sformatf("tmo_wait%0d", i), C_FRZ, 0, (i > CNT_MAX) ? CNT_MAX : i, 0, 0, 0);
    end
    @(negedge clk);
    applyStimulus(mk(1, 9, 0, 1, 0, 1, 1, 9, 0, 32'h0, 1, 1));
    #1 checkOutput("tmo_halt", C_HALT, 1, CNT_MAX, 0, 1, 0);
    @(negedge clk);
    applyStimulus(idle_s);
    #1 checkOutput("tmo_sticky", C_HALT, 1, CNT_MAX, 0, 1, 0);
    @(negedge clk);
    rst = 1'b1;
    modelReset();
    #1 checkOutput("halt_reset", C_BOOT, 0, 0, 0, 0, 0);

    // Ready on the last allowed wait cycle wins over the timeout
    doReset();
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      @(negedge clk);
      applyStimulus(s_frz);
    end
    @(negedge clk);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1));
    #1 checkOutput("ready_wins", C_NORM, 0, CNT_MAX, 0, 0, 0);
    @(negedge clk);
    applyStimulus(idle_s);
    #1 checkOutput("ready_wins_after", C_NORM, 0, CNT_MAX, 0, 0, 0);

    // Misaligned redirect halts without updating PC
    doReset();
    @(negedge clk);
    applyStimulus(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h102, 0, 0));
    #1 checkOutput("misalign", C_FRZ, 0, 0, 0, 0, 0);
    @(negedge clk);
    applyStimulus(idle_s);
    #1 checkOutput("misalign_halt", C_HALT, 1, 1, 0, 0, 1);

    // Random traffic against the model, with occasional asynchronous resets
    doReset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 149) == 0);
      if (rst) modelReset();
      s_rs = mk(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                ($urandom_range(0, 4) != 0), $urandom_range(0, 2) == 0,
                5'($urandom_range(0, 7)), $urandom_range(0, 9) == 0,
                {$urandom_range(0, 65535), 14'($urandom_range(0, 16383)),
                 ($urandom_range(0, 31) == 0) ? 2'($urandom_range(1, 3)) : 2'b00},
                $urandom_range(0, 9) < 3, $urandom_range(0, 1) != 0);
      applyStimulus(s_rs);
      #1 checkOutput("rand", modelCtrl(cur), m_halt, m_stall, m_flush, m_errt, m_errm);
    end
    @(negedge clk);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
